keypad_entry_ctrl: RTL and testbench
====================================

KEYPAD_ENTRY_CTRL -- requirements
Module: keypad_entry_ctrl

Interface
REQ-001 Parameter COUNT, default 4: number of digit slots in the downstream shift register.
REQ-002 Parameter WIDTH, default 4: key code and digit width in bits.
REQ-003 Parameter DEB_CYCLES, default 16: debounce stability window in clk cycles, minimum 2.
REQ-004 One clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all state updates on rising edge.
REQ-006 reset  input  1  asynchronous active-low reset.
REQ-007 key_pressed  input  1  raw, asynchronous, bouncy key-down level from the keypad scanner.
REQ-008 key_code  input  WIDTH  scanner key code, stable while key_pressed is high.
REQ-009 sr_trig  output  1  shift-register trigger; one-cycle high pulse, registered.
REQ-010 sr_in  output  WIDTH  shift-register data input, registered.
REQ-011 sr_dir  output  1  shift direction, tied 0 (left).
REQ-012 sr_reset  output  1  active-low shift-register clear; one-cycle low pulse, registered.
REQ-013 digit_cnt  output  $clog2(COUNT+1)  number of digits currently held.
REQ-014 entered  output  1  one-cycle pulse on accepted enter key.
REQ-015 locked  output  1  high after accepted enter until clear.
REQ-016 ovf  output  1  one-cycle pulse when a digit is rejected because the register is full.

Function
REQ-017 key_pressed SHALL pass through a 2-flop synchronizer (sync) before any use.
REQ-018 FSM states SHALL be IDLE, DEBOUNCE, ACT, EXEC, RELEASE.
REQ-019 IDLE: sync=1 -> DEBOUNCE, debounce counter cleared.
REQ-020 DEBOUNCE: sync=0 in any cycle -> IDLE, no action; sync=1 for DEB_CYCLES consecutive cycles -> ACT, key_code latched and loaded into sr_in on that transition edge.
REQ-021 ACT: one cycle; decode latched code: 0x0-0x9 digit, 0xA enter, 0xC clear, all others ignored; -> EXEC.
REQ-022 EXEC: one cycle; digit with locked=0 and digit_cnt<COUNT -> sr_trig=1, digit_cnt+1 on exit.
REQ-023 EXEC: digit with locked=0 and digit_cnt==COUNT -> ovf=1, no sr_trig, digit_cnt unchanged.
REQ-024 EXEC: digit with locked=1 -> no output activity.
REQ-025 EXEC: enter with digit_cnt>0 and locked=0 -> entered=1, locked set; enter with digit_cnt==0 or locked=1 ignored.
REQ-026 EXEC: clear -> sr_reset=0, digit_cnt<=0, locked<=0, regardless of state.
REQ-027 EXEC -> RELEASE unconditionally.
REQ-028 RELEASE: sync=0 for DEB_CYCLES consecutive cycles -> IDLE; any sync=1 restarts the count; no new key accepted before IDLE.
REQ-029 Latency: with bounce-free input and edge 0 the first edge sampling key_pressed high, the ACT transition occurs at edge DEB_CYCLES+2, sr_trig rises at edge DEB_CYCLES+3 and falls at edge DEB_CYCLES+4.
REQ-030 sr_in SHALL be stable at least one full cycle before and during sr_trig high.
REQ-031 sr_trig, sr_reset-low, entered, ovf SHALL each be exactly one cycle wide and mutually exclusive.
REQ-032 digit_cnt SHALL never exceed COUNT and never wrap.
REQ-033 Changes on key_code outside DEBOUNCE->ACT edge SHALL have no effect.

Reset
REQ-034 reset low SHALL immediately force: state IDLE, sync flops 0, counters 0, sr_trig 0, sr_in 0, sr_reset 1, digit_cnt 0, entered 0, locked 0, ovf 0.
REQ-035 reset asserted mid-operation (any state) SHALL abort it; no pulse completes; after release, a held key is processed as a new press from IDLE.

Verification
REQ-036 DEB_CYCLES=16, press code 0x5 clean -> sr_in=0x5 at edge 18, sr_trig high edges 19-20, digit_cnt=1.
REQ-037 Press 0x1,0x2,0x3,0x4,0x7 -> four sr_trig pulses, digit_cnt=4, fifth press gives ovf pulse, no sr_trig.
REQ-038 Press 0x9 with 5-cycle glitch then low -> no sr_trig, state back to IDLE; then press 0xA with digit_cnt=0 -> no entered.
REQ-039 Enter 0x3,0xA -> entered one pulse, locked=1; then 0x6 ignored; then 0xC -> sr_reset low one cycle, digit_cnt=0, locked=0.
REQ-040 Assert reset during DEBOUNCE and during EXEC -> all outputs at REQ-034 values immediately, no pulse emitted.
REQ-041 Bouncy release (sync toggling within window) -> RELEASE holds until DEB_CYCLES clean-low cycles, second press before then ignored.

Source files
------------

// File: rtl/keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// keypad_entry_ctrl
//
// Turns a raw, bouncy keypad press into clean, one-cycle control pulses for a
// downstream digit shift register. It accepts digits until the register is
// full, accepts an enter key that locks further entry, and accepts a clear
// key that empties the register and unlocks entry.
//
// Ports:
//   clk          system clock, all state updates on the rising edge
//   reset        asynchronous active-low reset
//   key_pressed  raw asynchronous key-down level from the scanner
//   key_code     scanner key code, valid while key_pressed is high
//   sr_trig      one-cycle shift trigger for the digit register
//   sr_in        digit presented to the register (registered)
//   sr_dir       shift direction, always left (0)
//   sr_reset     active-low one-cycle clear for the digit register
//   digit_cnt    number of digits currently held in the register
//   entered      one-cycle pulse when an enter key is accepted
//   locked       high from an accepted enter until the next clear
//   ovf          one-cycle pulse when a digit is rejected (register full)
// ---------------------------------------------------------------------------
module keypad_entry_ctrl #(
   parameter int COUNT      = 4,
   parameter int WIDTH      = 4,
   parameter int DEB_CYCLES = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       key_pressed,
   input  logic [WIDTH-1:0]           key_code,
   output logic                       sr_trig,
   output logic [WIDTH-1:0]           sr_in,
   output logic                       sr_dir,
   output logic                       sr_reset,
   output logic [$clog2(COUNT+1)-1:0] digit_cnt,
   output logic                       entered,
   output logic                       locked,
   output logic                       ovf
);

   localparam int CW = $clog2(COUNT + 1);
   localparam int DW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

   localparam logic [DW-1:0]    DEB_LAST    = DW'(DEB_CYCLES - 1);
   localparam logic [CW-1:0]    CNT_FULL    = CW'(COUNT);
   localparam logic [WIDTH-1:0] CODE_ENTER  = WIDTH'(10);
   localparam logic [WIDTH-1:0] CODE_CLEAR  = WIDTH'(12);

   typedef enum logic [2:0] {
      IDLE,
      DEBOUNCE,
      ACT,
      EXEC,
      RELEASE
   } state_t;

   state_t            state;
   state_t            state_next;
   logic              sync_meta;
   logic              sync;
   logic [DW-1:0]     deb_cnt;
   logic [DW-1:0]     deb_cnt_next;
   logic [WIDTH-1:0]  sr_in_next;
   logic              sr_trig_next;
   logic              sr_reset_next;
   logic              entered_next;
   logic              ovf_next;
   logic [CW-1:0]     digit_cnt_next;
   logic              locked_next;
   logic              is_digit;
   logic              is_enter;
   logic              is_clear;

   assign sr_dir = 1'b0;

   // sr_in doubles as the latched key code: it is captured on the
   // DEBOUNCE->ACT edge and stays put until the next accepted press, so
   // decoding straight from it keeps data and action consistent.
   assign is_digit = (sr_in < CODE_ENTER);
   assign is_enter = (sr_in == CODE_ENTER);
   assign is_clear = (sr_in == CODE_CLEAR);

   // Two-flop synchronizer: key_pressed is asynchronous to clk, so nothing
   // downstream looks at it before it has passed through both flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_meta <= 1'b0;
         sync      <= 1'b0;
      end else begin
         sync_meta <= key_pressed;
         sync      <= sync_meta;
      end
   end

   // State and output register. Every output is registered so the shift
   // register sees glitch-free pulses; the async reset drops any pulse in
   // flight so an aborted operation never completes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         deb_cnt   <= '0;
         sr_in     <= '0;
         sr_trig   <= 1'b0;
         sr_reset  <= 1'b1;
         entered   <= 1'b0;
         ovf       <= 1'b0;
         digit_cnt <= '0;
         locked    <= 1'b0;
      end else begin
         state     <= state_next;
         deb_cnt   <= deb_cnt_next;
         sr_in     <= sr_in_next;
         sr_trig   <= sr_trig_next;
         sr_reset  <= sr_reset_next;
         entered   <= entered_next;
         ovf       <= ovf_next;
         digit_cnt <= digit_cnt_next;
         locked    <= locked_next;
      end
   end

   // Next-state and next-output logic.
   // The decision about what a key does is taken in ACT and lands in the
   // pulse registers on the ACT->EXEC edge, so each pulse is high for exactly
   // the EXEC cycle. The bookkeeping (digit count, lock) is then updated on
   // the EXEC->RELEASE edge from those same pulse registers, which keeps the
   // count and the pulses from ever disagreeing.
   always_comb begin
      state_next     = state;
      deb_cnt_next   = deb_cnt;
      sr_in_next     = sr_in;
      sr_trig_next   = 1'b0;
      sr_reset_next  = 1'b1;
      entered_next   = 1'b0;
      ovf_next       = 1'b0;
      digit_cnt_next = digit_cnt;
      locked_next    = locked;

      case (state)
         IDLE: begin
            deb_cnt_next = '0;
            if (sync) begin
               state_next = DEBOUNCE;
            end
         end

         // The key must be seen high for DEB_CYCLES consecutive cycles; a
         // single low sample means it was a glitch and we drop it silently.
         DEBOUNCE: begin
            if (!sync) begin
               state_next   = IDLE;
               deb_cnt_next = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_next   = ACT;
               deb_cnt_next = '0;
               sr_in_next   = key_code;
            end else begin
               deb_cnt_next = deb_cnt + DW'(1);
            end
         end

         ACT: begin
            state_next = EXEC;
            if (is_digit && !locked) begin
               if (digit_cnt < CNT_FULL) begin
                  sr_trig_next = 1'b1;
               end else begin
                  ovf_next = 1'b1;
               end
            end
            if (is_enter && !locked && (digit_cnt != '0)) begin
               entered_next = 1'b1;
            end
            if (is_clear) begin
               sr_reset_next = 1'b0;
            end
         end

         EXEC: begin
            state_next   = RELEASE;
            deb_cnt_next = '0;
            if (sr_trig) begin
               digit_cnt_next = digit_cnt + CW'(1);
            end
            if (entered) begin
               locked_next = 1'b1;
            end
            if (!sr_reset) begin
               digit_cnt_next = '0;
               locked_next    = 1'b0;
            end
         end

         // Wait for a clean release: any high sample restarts the window,
         // so a bouncing release or an early second press is swallowed.
         RELEASE: begin
            if (sync) begin
               deb_cnt_next = '0;
            end else if (deb_cnt == DEB_LAST) begin
               state_next   = IDLE;
               deb_cnt_next = '0;
            end else begin
               deb_cnt_next = deb_cnt + DW'(1);
            end
         end

         default: begin
            state_next   = IDLE;
            deb_cnt_next = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// ---------------------------------------------------------------------------
// tb_keypad_entry_ctrl
//
// Directed self-checking bench for keypad_entry_ctrl with default
// parameters (COUNT=4, WIDTH=4, DEB_CYCLES=16). Expected values are worked
// out by hand from the intended behaviour and written as constants.
// ---------------------------------------------------------------------------
module tb_keypad_entry_ctrl;

   localparam int COUNT      = 4;
   localparam int WIDTH      = 4;
   localparam int DEB_CYCLES = 16;
   localparam int HOLD       = DEB_CYCLES + 8;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             key_pressed = 1'b0;
   logic [WIDTH-1:0] key_code = '0;
   logic             sr_trig;
   logic [WIDTH-1:0] sr_in;
   logic             sr_dir;
   logic             sr_reset;
   logic [2:0]       digit_cnt;
   logic             entered;
   logic             locked;
   logic             ovf;

   int checkCount   = 0;
   int errorCount   = 0;
   int trigCount    = 0;
   int srResetCount = 0;
   int enteredCount = 0;
   int ovfCount     = 0;
   int overlapCount = 0;

   keypad_entry_ctrl #(
      .COUNT      (COUNT),
      .WIDTH      (WIDTH),
      .DEB_CYCLES (DEB_CYCLES)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_pressed (key_pressed),
      .key_code    (key_code),
      .sr_trig     (sr_trig),
      .sr_in       (sr_in),
      .sr_dir      (sr_dir),
      .sr_reset    (sr_reset),
      .digit_cnt   (digit_cnt),
      .entered     (entered),
      .locked      (locked),
      .ovf         (ovf)
   );

   // 100 MHz-style clock, period 10 time units.
   always #5 clk = ~clk;

   // Pulse monitor. Outputs are registered on the rising edge, so sampling
   // on the falling edge sees each high cycle exactly once; a pulse that is
   // too wide or missing shows up as a wrong count, and any cycle with more
   // than one pulse active is tallied as an overlap.
   always @(negedge clk) begin
      int active;
      active = 0;
      if (sr_trig === 1'b1) begin
         trigCount++;
         active++;
      end
      if (sr_reset === 1'b0) begin
         srResetCount++;
         active++;
      end
      if (entered === 1'b1) begin
         enteredCount++;
         active++;
      end
      if (ovf === 1'b1) begin
         ovfCount++;
         active++;
      end
      if (active > 1) begin
         overlapCount++;
      end
   end

   // Single comparison point: counts the check and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   // All outputs at their reset values.
   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_sr_trig"},   32'(sr_trig),   32'd0);
      checkOutput({tag, "_sr_in"},     32'(sr_in),     32'd0);
      checkOutput({tag, "_sr_reset"},  32'(sr_reset),  32'd1);
      checkOutput({tag, "_digit_cnt"}, 32'(digit_cnt), 32'd0);
      checkOutput({tag, "_entered"},   32'(entered),   32'd0);
      checkOutput({tag, "_locked"},    32'(locked),    32'd0);
      checkOutput({tag, "_ovf"},       32'(ovf),       32'd0);
      checkOutput({tag, "_sr_dir"},    32'(sr_dir),    32'd0);
   endtask

   // Clean press and clean release, long enough to finish the whole cycle
   // back to IDLE before returning.
   task automatic applyStimulus(input logic [WIDTH-1:0] code);
      @(negedge clk);
      key_code    = code;
      key_pressed = 1'b1;
      repeat (HOLD) @(negedge clk);
      key_pressed = 1'b0;
      repeat (HOLD) @(negedge clk);
   endtask

   task automatic resetDut();
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   initial begin
      $display("[TB] keypad_entry_ctrl directed test start");

      // Reset state
      #1 reset = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Exact latency of a clean digit press (edge 0 samples the key high)
      @(negedge clk);
      key_code    = 4'h5;
      key_pressed = 1'b1;
      @(posedge clk);
      repeat (17) @(posedge clk);
      #1 checkOutput("lat_e17_sr_in", 32'(sr_in), 32'h0);
      @(posedge clk);
      #1 checkOutput("lat_e18_sr_in", 32'(sr_in), 32'h5);
      checkOutput("lat_e18_sr_trig", 32'(sr_trig), 32'd0);
      @(posedge clk);
      #1 checkOutput("lat_e19_sr_trig", 32'(sr_trig), 32'd1);
      checkOutput("lat_e19_digit_cnt", 32'(digit_cnt), 32'd0);
      @(posedge clk);
      #1 checkOutput("lat_e20_sr_trig", 32'(sr_trig), 32'd0);
      checkOutput("lat_e20_digit_cnt", 32'(digit_cnt), 32'd1);
      repeat (2) @(negedge clk);
      key_pressed = 1'b0;
      repeat (HOLD) @(negedge clk);
      checkOutput("lat_trig_count", 32'(trigCount), 32'd1);

      // Fill the register, then overflow it
      resetDut();
      applyStimulus(4'h1);
      applyStimulus(4'h2);
      applyStimulus(4'h3);
      applyStimulus(4'h4);
      checkOutput("fill_trig_count", 32'(trigCount), 32'd5);
      checkOutput("fill_digit_cnt", 32'(digit_cnt), 32'd4);
      checkOutput("fill_ovf_count", 32'(ovfCount), 32'd0);
      applyStimulus(4'h7);
      checkOutput("ovf_trig_count", 32'(trigCount), 32'd5);
      checkOutput("ovf_ovf_count", 32'(ovfCount), 32'd1);
      checkOutput("ovf_digit_cnt", 32'(digit_cnt), 32'd4);
      checkOutput("ovf_sr_in", 32'(sr_in), 32'h7);

      // Clear empties the register
      applyStimulus(4'hC);
      checkOutput("clr1_sr_reset_count", 32'(srResetCount), 32'd1);
      checkOutput("clr1_digit_cnt", 32'(digit_cnt), 32'd0);

      // Short glitch must be dropped without latching the code
      @(negedge clk);
      key_code    = 4'h9;
      key_pressed = 1'b1;
      repeat (5) @(negedge clk);
      key_pressed = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("glitch_trig_count", 32'(trigCount), 32'd5);
      checkOutput("glitch_sr_in", 32'(sr_in), 32'hC);

      // Enter with an empty register is ignored
      applyStimulus(4'hA);
      checkOutput("enter_empty_entered", 32'(enteredCount), 32'd0);
      checkOutput("enter_empty_locked", 32'(locked), 32'd0);
      checkOutput("enter_empty_sr_in", 32'(sr_in), 32'hA);

      // Digit, enter locks, digits and enters ignored, clear unlocks
      applyStimulus(4'h3);
      checkOutput("lock_digit_cnt", 32'(digit_cnt), 32'd1);
      checkOutput("lock_trig_count", 32'(trigCount), 32'd6);
      applyStimulus(4'hA);
      checkOutput("lock_entered_count", 32'(enteredCount), 32'd1);
      checkOutput("lock_locked", 32'(locked), 32'd1);
      applyStimulus(4'h6);
      checkOutput("locked_digit_trig", 32'(trigCount), 32'd6);
      checkOutput("locked_digit_ovf", 32'(ovfCount), 32'd1);
      checkOutput("locked_digit_cnt", 32'(digit_cnt), 32'd1);
      applyStimulus(4'hA);
      checkOutput("locked_enter_count", 32'(enteredCount), 32'd1);
      applyStimulus(4'hC);
      checkOutput("clr2_sr_reset_count", 32'(srResetCount), 32'd2);
      checkOutput("clr2_digit_cnt", 32'(digit_cnt), 32'd0);
      checkOutput("clr2_locked", 32'(locked), 32'd0);

      // Reset during DEBOUNCE; the held key is then taken as a new press
      @(negedge clk);
      key_code    = 4'h8;
      key_pressed = 1'b1;
      @(posedge clk);
      repeat (10) @(posedge clk);
      #2 reset = 1'b0;
      #1 checkResetValues("rst_deb");
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (HOLD) @(negedge clk);
      key_pressed = 1'b0;
      repeat (HOLD) @(negedge clk);
      checkOutput("rst_deb_trig_count", 32'(trigCount), 32'd7);
      checkOutput("rst_deb_digit_cnt", 32'(digit_cnt), 32'd1);
      checkOutput("rst_deb_sr_in", 32'(sr_in), 32'h8);

      // Reset during EXEC aborts the trigger pulse
      @(negedge clk);
      key_code    = 4'h4;
      key_pressed = 1'b1;
      @(posedge clk);
      repeat (19) @(posedge clk);
      #2 checkOutput("rst_exec_pre_trig", 32'(sr_trig), 32'd1);
      reset = 1'b0;
      #1 checkResetValues("rst_exec");
      @(negedge clk);
      key_pressed = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (HOLD) @(negedge clk);
      checkOutput("rst_exec_trig_count", 32'(trigCount), 32'd7);
      checkOutput("rst_exec_digit_cnt", 32'(digit_cnt), 32'd0);

      // Bouncy release plus an early second press must both be swallowed
      @(negedge clk);
      key_code    = 4'h2;
      key_pressed = 1'b1;
      repeat (HOLD) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         key_pressed = 1'b0;
         repeat (6) @(negedge clk);
         key_pressed = 1'b1;
         repeat (2) @(negedge clk);
      end
      key_pressed = 1'b0;
      repeat (8) @(negedge clk);
      key_code    = 4'h3;
      key_pressed = 1'b1;
      repeat (30) @(negedge clk);
      key_pressed = 1'b0;
      repeat (30) @(negedge clk);
      checkOutput("bounce_trig_count", 32'(trigCount), 32'd8);
      checkOutput("bounce_digit_cnt", 32'(digit_cnt), 32'd1);
      checkOutput("bounce_sr_in", 32'(sr_in), 32'h2);
      applyStimulus(4'h3);
      checkOutput("after_bounce_digit_cnt", 32'(digit_cnt), 32'd2);
      checkOutput("after_bounce_sr_in", 32'(sr_in), 32'h3);
      checkOutput("after_bounce_trig_count", 32'(trigCount), 32'd9);

      // Pulses never overlapped over the whole run
      checkOutput("pulse_overlap", 32'(overlapCount), 32'd0);

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
